// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, write-through bypass,
// optional hardwired zero register and a per-register pending-write scoreboard.
module regfile_mp #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_set_addr,
    output logic [DEPTH-1:0]     busy,
    output logic [NRD-1:0]       rd_hazard
);

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0]     r_busy;
    logic [DEPTH-1:0]     w_busy_nxt;
    logic [NRD*WIDTH-1:0] r_rd_data_p1;
    logic [NRD-1:0]       r_rd_vld_p1;
    logic                 w_wr_ok;
    logic                 w_set_ok;
    logic [AW-1:0]        w_rd_addr [NRD];
    logic [WIDTH-1:0]     w_rd_val  [NRD];
    logic [NRD-1:0]       w_hit;
    logic [NRD-1:0]       w_hazard;

    // Writes and scoreboard sets to register 0 or beyond DEPTH are dropped here,
    // so nothing downstream has to re-check them.
    assign w_wr_ok  = wr_en && in_range(wr_addr) && !is_zero(wr_addr);
    assign w_set_ok = busy_set && in_range(busy_set_addr) && !is_zero(busy_set_addr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // A set wins over a clearing write: the new producer is still outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_set_ok && (busy_set_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b1;
            end else if (w_wr_ok && (wr_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_hit    = '0;
        w_hazard = '0;
        for (int i = 0; i < NRD; i++) begin
            w_rd_addr[i] = rd_addr[i*AW +: AW];
            w_rd_val[i]  = '0;
            w_hit[i]     = w_wr_ok && (wr_addr == w_rd_addr[i]);
            if (in_range(w_rd_addr[i]) && !is_zero(w_rd_addr[i])) begin
                w_rd_val[i] = w_hit[i] ? wr_data : r_mem[w_rd_addr[i]];
                w_hazard[i] = r_busy[w_rd_addr[i]] && !w_hit[i];
            end
        end
    end

    // Read stage p1: data holds when a port is idle, valid pulses per request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data_p1 <= '0;
            r_rd_vld_p1  <= '0;
        end else begin
            r_rd_vld_p1 <= rd_en;
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    r_rd_data_p1[i*WIDTH +: WIDTH] <= w_rd_val[i];
                end
            end
        end
    end

    assign rd_data   = r_rd_data_p1;
    assign rd_valid  = r_rd_vld_p1;
    assign busy      = r_busy;
    assign rd_hazard = w_hazard;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: read expectations are queued when a request
// is driven and popped after the read edge.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        busy_set;
    logic [4:0]  busy_set_addr;
    logic [31:0] busy;
    logic [1:0]  rd_hazard;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [32];
    logic [31:0] mb;
    int          n_checks = 0;
    int          n_pass   = 0;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy_set      (busy_set),
        .busy_set_addr (busy_set_addr),
        .busy          (busy),
        .rd_hazard     (rd_hazard)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        busy_set = 1'b0; busy_set_addr = '0;
    endtask

    // Drives one clock of stimulus, queues read expectations, advances the model.
    task automatic drive_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic bs, input logic [4:0] ba);
        logic [4:0] ra [2];
        exp_t       e;
        ra[0] = ra0;
        ra[1] = ra1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = {ra1, ra0};
        busy_set = bs; busy_set_addr = ba;
        for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
                e.port = p;
                if (ra[p] == 5'd0)            e.data = 32'h0;
                else if (we && wa == ra[p])   e.data = wd;
                else                          e.data = mdl[ra[p]];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        if (we && wa != 5'd0) mdl[wa] = wd;
        for (int k = 1; k < 32; k++) begin
            if (bs && ba == 5'(k))      mb[k] = 1'b1;
            else if (we && wa == 5'(k)) mb[k] = 1'b0;
        end
        #1;
        idle_inputs();
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
        mb = 32'h0;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        n_checks++;
        if (rd_valid !== 2'b00) $display("FAIL reset_rd_valid: got %b want 00", rd_valid);
        else n_pass++;
        n_checks++;
        if (rd_data !== 64'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data);
        else n_pass++;
        n_checks++;
        if (busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        for (int a = 0; a < 32; a++) begin
            drive_cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(31 - a), 1'b0, 5'd0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                    $display("FAIL reset_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                             e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL write_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        n_checks++;
        if (rd_valid !== 2'b00 || rd_data !== {2{32'hDEADBEEF}})
            $display("FAIL idle_hold: got valid=%b data=%h want valid=00 data=%h",
                     rd_valid, rd_data, {2{32'hDEADBEEF}});
        else n_pass++;
    endtask

    task automatic test_bypass();
        exp_t e;
        drive_cycle(1'b1, 5'd7, 32'h1234, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL bypass port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
        n_checks++;
        if (rd_valid[1] !== 1'b0) $display("FAIL bypass_port1_idle: got %b want 0", rd_valid[1]);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        exp_t e;
        drive_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0);
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL zero_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
        n_checks++;
        if (busy[0] !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy[0]);
        else n_pass++;
        rd_addr = 10'd0;
        #1;
        n_checks++;
        if (rd_hazard !== 2'b00) $display("FAIL zero_hazard: got %b want 00", rd_hazard);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        exp_t e;
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        n_checks++;
        if (busy !== mb || busy[3] !== 1'b1) $display("FAIL busy_set: got %h want %h", busy, mb);
        else n_pass++;
        rd_addr = {5'd4, 5'd3};
        #1;
        n_checks++;
        if (rd_hazard !== 2'b01) $display("FAIL hazard_set: got %b want 01", rd_hazard);
        else n_pass++;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        #1;
        n_checks++;
        if (rd_hazard !== 2'b00) $display("FAIL hazard_write_mask: got %b want 00", rd_hazard);
        else n_pass++;
        drive_cycle(1'b1, 5'd3, 32'hA5, 2'b00, 5'd3, 5'd4, 1'b0, 5'd0);
        n_checks++;
        if (busy !== mb || busy[3] !== 1'b0) $display("FAIL busy_clear: got %h want %h", busy, mb);
        else n_pass++;
        drive_cycle(1'b1, 5'd3, 32'hBEEF, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        n_checks++;
        if (busy !== mb || busy[3] !== 1'b1) $display("FAIL busy_set_wins: got %h want %h", busy, mb);
        else n_pass++;
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b0, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL set_write_data port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int n = 0; n < 40; n++) begin
            drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                        2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                        5'($urandom_range(0, 31)));
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                    $display("FAIL random_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                             e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
                else n_pass++;
            end
            n_checks++;
            if (busy !== mb) $display("FAIL random_busy: got %h want %h", busy, mb);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive_cycle(1'b1, 5'd9, 32'h55, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12);
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL pre_reset_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 2'b00 || rd_data !== 64'h0)
            $display("FAIL async_reset_read: got valid=%b data=%h want valid=00 data=0", rd_valid, rd_data);
        else n_pass++;
        n_checks++;
        if (busy !== 32'h0) $display("FAIL async_reset_busy: got %h want 0", busy);
        else n_pass++;
        clear_model();
        @(negedge clk);
        resetn = 1'b1;
        drive_cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd5, 1'b0, 5'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_valid[e.port] !== 1'b1 || rd_data[e.port*32 +: 32] !== e.data)
                $display("FAIL post_reset_read port%0d: got valid=%b data=%h want valid=1 data=%h",
                         e.port, rd_valid[e.port], rd_data[e.port*32 +: 32], e.data);
            else n_pass++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
